fp_mac_seq_master: RTL

//  Avalon-MM master that drives the fp_mac accelerator slave to compute a float32 dot product.

---
 rtl/fp_mac_pkg.sv | 22 ++
 rtl/fp_mac_seq_master.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fp_mac_pkg.sv
// Shared definitions for the fp_mac accelerator and its sequencing master:
// FSM state encoding, slave register map and float32 constants.
package fp_mac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WR_A  = 3'd2,
    WR_B  = 3'd3,
    WR_C  = 3'd4,
    RD    = 3'd5,
    RWAIT = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam logic [2:0]  FP_MAC_ADDR_A   = 3'd0;
  localparam logic [2:0]  FP_MAC_ADDR_B   = 3'd1;
  localparam logic [2:0]  FP_MAC_ADDR_C   = 3'd2;
  localparam logic [2:0]  FP_MAC_ADDR_RES = 3'd0;
  localparam logic [31:0] FP32_ZERO       = 32'h0;

endpackage

// File: rtl/fp_mac_seq_master.sv
// Avalon-MM master sequencing the fp_mac slave through a float32 dot product.
// Optional FP_MAC_SEQ_WAITREQ_EN: honour avm_waitrequest on every bus phase.
module fp_mac_seq_master
  import fp_mac_pkg::*;
#(
  parameter int LEN_W        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      acc_init,
  output logic             busy,
  input  logic             op_valid,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             op_ready,
  output logic             res_valid,
  output logic [31:0]      res_data,
  input  logic             res_ready,
  output logic [2:0]       avm_address,
  output logic [31:0]      avm_writedata,
  output logic             avm_write,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_t           state;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [31:0]      acc;
  logic [LEN_W-1:0] rem;
  logic [2:0]       lat_cnt;
  logic             stall;

`ifdef FP_MAC_SEQ_WAITREQ_EN
  assign stall = avm_waitrequest;
`else
  logic unused_waitrequest;
  assign unused_waitrequest = avm_waitrequest;
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      a       <= FP32_ZERO;
      b       <= FP32_ZERO;
      acc     <= FP32_ZERO;
      rem     <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= acc_init;
            rem   <= len;
            state <= (len == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (op_valid) begin
            a     <= op_a;
            b     <= op_b;
            state <= WR_A;
          end
        end
        WR_A: if (!stall) state <= WR_B;
        WR_B: if (!stall) state <= WR_C;
        WR_C: if (!stall) state <= RD;
        RD: begin
          if (!stall) begin
            lat_cnt <= '0;
            state   <= RWAIT;
          end
        end
        // Readdata is valid on the final latency count only.
        RWAIT: begin
          if (lat_cnt == LAT_LAST) begin
            acc   <= avm_readdata;
            rem   <= rem - LEN_W'(1);
            state <= (rem == LEN_W'(1)) ? DONE : FETCH;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    avm_address   = FP_MAC_ADDR_A;
    avm_writedata = FP32_ZERO;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    case (state)
      WR_A: begin
        avm_write     = 1'b1;
        avm_address   = FP_MAC_ADDR_A;
        avm_writedata = a;
      end
      WR_B: begin
        avm_write     = 1'b1;
        avm_address   = FP_MAC_ADDR_B;
        avm_writedata = b;
      end
      WR_C: begin
        avm_write     = 1'b1;
        avm_address   = FP_MAC_ADDR_C;
        avm_writedata = acc;
      end
      RD: begin
        avm_read    = 1'b1;
        avm_address = FP_MAC_ADDR_RES;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign op_ready  = (state == FETCH);
  assign res_valid = (state == DONE);
  assign res_data  = acc;

endmodule
